mips_bus_memory: RTL and testbench

Synthesizable word-addressed memory responder for the `mips_cpu_bus` data/instruction port. It sits on the far end of the CPU's Avalon-style bus and replaces ad-hoc per-testbench memory arrays with one parameterised block. It maps the reset-vector region, applies byte-enabled writes and serves registered reads. It inserts a programmable number of `waitrequest` stall cycles so CPU handshake logic is exercised under back-pressure.

---
 rtl/mips_bus_pkg.sv | 29 ++
 rtl/bus_wait_ctrl.sv | 70 +++++++
 rtl/mips_bus_memory.sv | 98 +++++++++
 tb/tb_mips_bus_memory.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the mips_cpu_bus memory responder: reset vector,
// byte-enable constants, wait-state FSM encoding and a lane-merge helper.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bus_wait_state_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_wait_ctrl.sv
// Wait-state controller: stretches each bus request by WAIT_STATES cycles of
// waitrequest, plus any cycles where the external stall input is high.
module bus_wait_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic stall_i,
  output logic waitrequest_o
);

  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic       WAIT_EN = (WAIT_STATES != 0);

  bus_wait_state_t state_q, state_d;
  logic [3:0]      cnt_q,   cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && WAIT_EN) begin
          cnt_d   = 4'd1;
          state_d = (WS == 4'd1) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == WS) state_d = READY;
        end
      end
      READY: begin
        // Leaves on acceptance (stall low) or when the CPU drops the request.
        if (!req_i || !stall_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign waitrequest_o = stall_i | (req_i & (state_q != READY) & WAIT_EN);

endmodule

// File: rtl/mips_bus_memory.sv
// Word-addressed memory responder for the mips_cpu_bus port: address decode,
// byte-enabled writes, registered reads, sticky bus_error and wait states.
module mips_bus_memory
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        stall,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             addr_ok;
  logic             addr_zero;
  logic             req;
  logic             accept;
  logic             do_write;
  logic [31:0]      readdata_q, readdata_d;
  logic             bus_error_q, bus_error_d;

  assign req    = read | write;
  assign accept = req & ~waitrequest;

  bus_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctrl (
    .clk          (clk),
    .rst_n        (reset),
    .req_i        (req),
    .stall_i      (stall),
    .waitrequest_o(waitrequest)
  );

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign offset    = address - BASE_ADDR;
  assign word_idx  = offset[IDX_W+1:2];
  assign addr_ok   = (offset < 32'(DEPTH_WORDS * 4)) && (address[1:0] == 2'b00);
  assign addr_zero = (address == 32'h0);
  assign do_write  = accept & write & ~read & addr_ok;

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
  end

  // NOTE: the storage array is deliberately left out of reset; clearing it
  // would prevent RAM inference and wipe preloaded program images.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[word_idx] <= merge_lanes(mem_q[word_idx], writedata, byteenable);
  end

  always_comb begin
    readdata_d  = readdata_q;
    bus_error_d = bus_error_q;
    if (accept) begin
      if (read && write) begin
        readdata_d  = '0;
        bus_error_d = 1'b1;
      end else if (read) begin
        readdata_d = addr_ok ? mem_q[word_idx] : '0;
        // Address 0 is the CPU's halt fetch and is not treated as a fault.
        if (!addr_ok && !addr_zero) bus_error_d = 1'b1;
      end else if (!addr_ok) begin
        bus_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign readdata  = readdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Scoreboard bench for mips_bus_memory: two instances (0 and 3 wait states)
// driven with directed and random traffic against a word-array reference model.
module tb_mips_bus_memory;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic        stall_s[2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [3:0]  be_s   [2];
  logic        wreq   [2];
  logic [31:0] rdata  [2];
  logic        berr   [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] ref_rd  [2];
  logic        ref_err [2];
  int          exp_waits[2];
  exp_t        q0[$];
  exp_t        q1[$];
  bit          acc0, acc1;

  always #5 clk = ~clk;

  mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .clk(clk), .reset(reset), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .writedata(wd_s[0]), .byteenable(be_s[0]), .stall(stall_s[0]),
    .waitrequest(wreq[0]), .readdata(rdata[0]), .bus_error(berr[0]));

  mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
    .clk(clk), .reset(reset), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .writedata(wd_s[1]), .byteenable(be_s[1]), .stall(stall_s[1]),
    .waitrequest(wreq[1]), .readdata(rdata[1]), .bus_error(berr[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: applied at the moment a request is known to be accepted.
  task automatic model_apply(input int d, input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] off;
    logic [31:0] mask;
    bit          inr;
    int          idx;
    exp_t        e;
    off  = a - BASE;
    inr  = (off < DEPTH * 4) && (a % 4 == 0);
    idx  = int'(off / 4);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (r && w) begin
      ref_rd[d]  = 32'h0;
      ref_err[d] = 1'b1;
    end else if (w) begin
      if (inr) ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | (wd & mask);
      else     ref_err[d] = 1'b1;
    end else if (inr) begin
      ref_rd[d] = ref_mem[d][idx];
    end else begin
      ref_rd[d] = 32'h0;
      if (a != 32'h0) ref_err[d] = 1'b1;
    end
    e.rdata = ref_rd[d];
    e.err   = ref_err[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; returns once the request has been accepted.
  task automatic bus_op(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    int waits;
    waits      = 0;
    rd_s[d]    = r;
    wr_s[d]    = w;
    addr_s[d]  = a;
    wd_s[d]    = wd;
    be_s[d]    = be;
    #1;
    while (wreq[d] && waits < 40) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check($sformatf("wait_cycles[%0d]", d), 32'(waits), 32'(exp_waits[d]));
    if (waits < 40) begin
      model_apply(d, r, w, a, wd, be);
      @(posedge clk);
      #1;
    end
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_accept[%0d]: got acceptance expected none at %0t", d, $time);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("readdata[%0d]", d), rdata[d], e.rdata);
      check($sformatf("bus_error[%0d]", d), 32'(berr[d]), 32'(e.err));
    end
  endtask

  // Monitor: detects acceptance at the edge, compares registered outputs after it.
  always @(posedge clk) begin
    acc0 = reset && (rd_s[0] || wr_s[0]) && !wreq[0];
    acc1 = reset && (rd_s[1] || wr_s[1]) && !wreq[1];
    #1;
    if (acc0) pop_check(0);
    if (acc1) pop_check(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int          d;
    int          k;
    int          widx;
    bit          r;
    bit          w;

    exp_waits[0] = 0;
    exp_waits[1] = 3;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 0; wr_s[i] = 0; stall_s[i] = 0;
      addr_s[i] = 0; wd_s[i] = 0; be_s[i] = 0;
      ref_rd[i] = 0; ref_err[i] = 0;
    end
    reset = 1'b0;

    // Reset state and the combinational waitrequest path.
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_readdata[%0d]", i), rdata[i], 32'h0);
      check($sformatf("rst_bus_error[%0d]", i), 32'(berr[i]), 32'h0);
      check($sformatf("rst_waitreq[%0d]", i), 32'(wreq[i]), 32'h0);
    end
    stall_s[0] = 1'b1;
    #1;
    check("rst_stall_waitreq", 32'(wreq[0]), 32'h1);
    stall_s[0] = 1'b0;
    #5;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Known contents everywhere; each op also checks the wait count.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) begin
        v = $urandom;
        bus_op(i, 1'b0, 1'b1, BASE + 32'(j * 4), v, 4'b1111);
      end

    // mem[6] = 111, read back with no wait states.
    bus_op(0, 1'b0, 1'b1, 32'hBFC00018, 32'd111, 4'b1111);
    bus_op(0, 1'b1, 1'b0, 32'hBFC00018, 32'h0, 4'b0000);

    // Byte-lane merges on both instances.
    for (int i = 0; i < 2; i++) begin
      bus_op(i, 1'b0, 1'b1, BASE + 32'h14, 32'h11223344, 4'b1111);
      bus_op(i, 1'b0, 1'b1, BASE + 32'h14, 32'hAABBCCDD, 4'b0010);
      bus_op(i, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'b0000);
      bus_op(i, 1'b0, 1'b1, BASE + 32'h14, 32'h11223344, 4'b1111);
      bus_op(i, 1'b0, 1'b1, BASE + 32'h14, 32'hAABBCCDD, 4'b1100);
      bus_op(i, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'b0000);
      bus_op(i, 1'b0, 1'b1, BASE + 32'h18, 32'h55667788, 4'b0000);
      bus_op(i, 1'b1, 1'b0, BASE + 32'h18, 32'h0, 4'b0000);
    end

    // Back-to-back reads with 3 wait states each.
    bus_op(1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'b0000);
    bus_op(1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'b0000);

    // Decode boundaries and the sticky error on the 0-wait instance.
    bus_op(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
    bus_op(0, 1'b1, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h0, 4'b0000);
    bus_op(0, 1'b1, 1'b0, 32'h00001000, 32'h0, 4'b0000);
    bus_op(0, 1'b1, 1'b0, BASE, 32'h0, 4'b0000);
    bus_op(0, 1'b0, 1'b1, 32'hBFC00002, 32'hFFFFFFFF, 4'b1111);
    bus_op(0, 1'b1, 1'b0, BASE, 32'h0, 4'b0000);
    bus_op(0, 1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'b0000);
    bus_op(0, 1'b1, 1'b0, BASE - 32'd4, 32'h0, 4'b0000);

    // Read and write together on the 3-wait instance.
    bus_op(1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'b0000);
    bus_op(1, 1'b1, 1'b1, BASE + 32'h8, 32'h0BADF00D, 4'b1111);
    bus_op(1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'b0000);

    // Request dropped in WAIT: the next request pays the full count.
    rd_s[1] = 1'b1; addr_s[1] = BASE + 32'h4;
    repeat (2) begin @(posedge clk); #1; end
    rd_s[1] = 1'b0;
    @(posedge clk);
    #1;
    bus_op(1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'b0000);

    // Stall held for 5 cycles while in READY.
    rd_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = BASE + 32'hC;
    repeat (3) begin @(posedge clk); #1; end
    stall_s[1] = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      check("stall_hold", 32'(wreq[1]), 32'h1);
      @(posedge clk);
      #1;
    end
    stall_s[1] = 1'b0;
    #1;
    check("stall_release", 32'(wreq[1]), 32'h0);
    model_apply(1, 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'b0000);
    @(posedge clk);
    #1;
    rd_s[1] = 1'b0;

    // Reset during a pending write: the write must never happen.
    bus_op(1, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'b0000);
    wr_s[1] = 1'b1; addr_s[1] = BASE + 32'h28; wd_s[1] = 32'hDEADBEEF; be_s[1] = 4'b1111;
    repeat (2) begin @(posedge clk); #1; end
    check("pending_waitreq", 32'(wreq[1]), 32'h1);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midwait_rst_readdata[%0d]", i), rdata[i], 32'h0);
      check($sformatf("midwait_rst_bus_error[%0d]", i), 32'(berr[i]), 32'h0);
      ref_rd[i]  = 32'h0;
      ref_err[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    wr_s[1] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_op(1, 1'b1, 1'b0, BASE + 32'h28, 32'h0, 4'b0000);

    // Random mixed traffic.
    for (int n = 0; n < 150; n++) begin
      d    = int'($urandom_range(1, 0));
      k    = int'($urandom_range(99, 0));
      widx = int'($urandom_range(DEPTH - 1, 0));
      if (k < 80)      a = BASE + 32'(widx * 4);
      else if (k < 88) a = BASE + 32'(widx * 4) + 32'($urandom_range(3, 1));
      else if (k < 94) a = BASE + 32'(DEPTH * 4) + 32'(widx * 4);
      else if (k < 97) a = BASE - 32'd4;
      else             a = 32'h0;
      k = int'($urandom_range(99, 0));
      r = (k < 50) || (k >= 96);
      w = (k >= 50);
      bus_op(d, r, w, a, $urandom, 4'($urandom_range(15, 0)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
